vga_text_fetch: RTL and testbench
=================================

// Module: vga_text_fetch
// PURPOSE
//  Text-mode scanline sequencer for the VGA char ROM (8x16 font, 256 glyphs, 1-cycle sync read).
//  Per line: fetches {attr,char} words from text RAM and looks up the font row in char ROM.
//  Queues decoded cells and serialises 8 pixels/cell to a 4-bit colour index.
//  Also grants CPU font writes into the char ROM port when the fetch FSM leaves it idle.
// PARAMETERS
//  COLS     80  character cells fetched per line (1..255)
//  ADDR_W   12  text RAM word address width
//  FIFO_DEP 2   cell FIFO depth, power of 2, >=2
// PORTS
//  clk        in   1       pixel clock; all logic rising-edge
//  rst        in   1       asynchronous, active-low reset
//  line_req   in   1       1-cycle pulse: start fetching a new line (>=8*FIFO_DEP clk before de)
//  line_base  in   ADDR_W  text RAM word address of cell 0, sampled on line_req
//  line_row   in   4       font row 0..15, sampled on line_req
//  de         in   1       display enable; one pixel consumed per cycle while high
//  blink      in   1       blink phase; 1 = blinking glyphs hidden
//  txt_req    out  1       text RAM read request, held until txt_ack
//  txt_addr   out  ADDR_W  text RAM word address, stable while txt_req
//  txt_ack    in   1       request accepted; txt_data valid this cycle
//  txt_data   in   16      [15:8] attr, [7:0] char code
//  rom_cs     out  1       char ROM enable
//  rom_we     out  1       char ROM write strobe
//  rom_addr   out  12      {char[7:0], row[3:0]}
//  rom_wdata  out  8       write data (CPU path)
//  rom_rdata  in   8       font byte, valid cycle after rom_cs&~rom_we
//  cpu_we     in   1       font write request, held until cpu_ack
//  cpu_addr   in   12      font write address
//  cpu_wdata  in   8       font write data
//  cpu_ack    out  1       1-cycle pulse: write performed
//  pix_color  out  4       pixel colour index, registered
//  underrun   out  1       sticky: cell needed but FIFO empty; cleared by line_req
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, all outputs 0.
//  Fetch FSM: IDLE -line_req-> TXT_REQ (txt_req=1, addr=base+col) -txt_ack-> ROM_RD
//   (rom_cs=1, we=0, addr={char,row}; latch attr) -> ROM_DAT (push {attr,rom_rdata}, col++)
//   -> TXT_REQ if col<COLS & !full; WAIT if full; IDLE if col==COLS.
//   WAIT -> TXT_REQ when FIFO not full.
//  txt_addr wraps modulo 2^ADDR_W. col is 8 bits.
//  line_req in any state: abort, flush FIFO, clear underrun, col=0, TXT_REQ next cycle.
//   An outstanding txt_req is dropped; a late txt_ack is ignored outside TXT_REQ.
//  Shifter: de high with bit counter 0 -> pop cell, emit bit7; bits 6..0 on next 7 cycles.
//   Font is MSB = leftmost pixel.
//  de low: counter resets to 0, pix_color=0. de->pix_color latency 1 clk.
//  Colour: on = bit & ~(attr[7] & blink).
//   pix_color = on ? attr[3:0] : {1'b0,attr[6:4]}.
//  Empty FIFO at pop: underrun=1, output cell treated as 0x0000 (colour 0) for those 8 pixels.
//  Simultaneous pop & push on a full FIFO is legal; occupancy is unchanged.
//  CPU arbitration: fetch has priority. CPU write is issued in any cycle the FSM is not in ROM_RD
//   (rom_cs=1, rom_we=1, addr/wdata=cpu_*). cpu_ack pulses the same cycle.
//   cpu_ack is never asserted twice for one request; the requester drops cpu_we after ack.
//  Reset mid-operation: immediate return to reset state; no handshake is completed.
// STRUCTURE
//  vga_text_defs.vh: CHAR_W=8, FONT_ROWS=16, FSM state encodings, attr field positions.
//  Sub-module vga_cell_fifo: sync FIFO of 16-bit {attr,font} cells.
//   push/pop/full/empty, same-cycle push+pop.
//  Top: fetch FSM, ROM port mux/arbiter, pixel shifter + colour decode.
// TESTING
//  1: base=0x100, row=5, RAM[0x100]=0x1741, txt_ack 1 cycle late.
//     -> rom_addr=0x415, rom_rdata=0xC6 -> first 8 pixels 7,7,1,1,1,7,7,1.
//  2: COLS=80, ack every cycle, de 640 cycles -> exactly 80 txt_req handshakes, underrun stays 0.
//  3: txt_ack stalled 40 cycles mid-line -> underrun=1, affected pixels 0; next line_req clears it.
//  4: cpu_we held through a fetch burst -> write only in non-ROM_RD cycles, single cpu_ack.
//     A later read of the same address returns the written byte.
//  5: attr=0x8F, blink=1, glyph byte 0xFF -> all pixels 0; blink=0 -> all pixels 0xF.
//  6: line_req during TXT_REQ with 1 cell queued, then rst low mid-line.
//     -> FIFO flushed, new base fetched. After reset all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/vga_text_fetch_pkg.sv
// Shared types and constants for the VGA text-mode fetch pipeline.
package vga_text_fetch_pkg;

    localparam int unsigned CHAR_W    = 8;
    localparam int unsigned FONT_ROWS = 16;
    localparam int unsigned ROW_W     = 4;
    localparam int unsigned ROM_AW    = 12;
    localparam int unsigned COL_W     = 8;
    localparam int unsigned COLOR_W   = 4;
    localparam int unsigned ATTR_BLINK = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TXT_REQ = 3'd1,
        ST_ROM_RD  = 3'd2,
        ST_ROM_DAT = 3'd3,
        ST_WAIT    = 3'd4
    } fetch_state_t;

    typedef struct packed {
        logic [CHAR_W-1:0] attr;
        logic [CHAR_W-1:0] font;
    } cell_t;

    // Foreground when the glyph bit is set and not blanked by blink, else background.
    function automatic logic [COLOR_W-1:0] pix_colour(input logic [CHAR_W-1:0] attr,
                                                      input logic bit_v,
                                                      input logic blink_v);
        logic on;
        on = bit_v & ~(attr[ATTR_BLINK] & blink_v);
        return on ? attr[3:0] : {1'b0, attr[6:4]};
    endfunction

endpackage

// File: rtl/vga_cell_fifo.sv
// Small synchronous FIFO of decoded {attr,font} cells with show-ahead read data.
module vga_cell_fifo
    import vga_text_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push,
    input  cell_t                     wdata,
    input  logic                      pop,
    output cell_t                     rdata,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    cell_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is only accepted when a pop frees the slot the same cycle.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign full    = (cnt == LW'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/vga_text_fetch.sv
// Text-mode scanline fetch: text RAM -> char ROM -> cell FIFO -> 8-pixel serialiser,
// with CPU font writes slotted into ROM cycles the fetch does not need.
module vga_text_fetch
    import vga_text_fetch_pkg::*;
#(
    parameter int unsigned COLS     = 80,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned FIFO_DEP = 2
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                line_req,
    input  logic [ADDR_W-1:0]   line_base,
    input  logic [3:0]          line_row,
    input  logic                de,
    input  logic                blink,
    output logic                txt_req,
    output logic [ADDR_W-1:0]   txt_addr,
    input  logic                txt_ack,
    input  logic [15:0]         txt_data,
    output logic                rom_cs,
    output logic                rom_we,
    output logic [11:0]         rom_addr,
    output logic [7:0]          rom_wdata,
    input  logic [7:0]          rom_rdata,
    input  logic                cpu_we,
    input  logic [11:0]         cpu_addr,
    input  logic [7:0]          cpu_wdata,
    output logic                cpu_ack,
    output logic [3:0]          pix_color,
    output logic                underrun
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEP) + 1;

    fetch_state_t      state;
    fetch_state_t      state_nx;
    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  col_nx;
    logic [ADDR_W-1:0] base_q;
    logic [ROW_W-1:0]  row_q;
    logic [CHAR_W-1:0] attr_q;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    cell_t             fifo_head;
    cell_t             push_cell;
    cell_t             pop_cell;

    logic              cpu_go;
    logic              fill_after;
    logic [2:0]        bit_cnt;
    cell_t             cur_q;

    assign fifo_push  = (state == ST_ROM_DAT) & ~line_req;
    assign fifo_pop   = de & (bit_cnt == 3'd0) & ~fifo_empty;
    assign push_cell  = '{attr: attr_q, font: rom_rdata};
    assign pop_cell   = fifo_empty ? '0 : fifo_head;
    assign fill_after = (fifo_level == LVL_W'(FIFO_DEP - 1)) & ~fifo_pop;
    // Ack is still high during the cycle after a write, so a held cpu_we is not reissued.
    assign cpu_go     = cpu_we & ~cpu_ack & (state_nx != ST_ROM_RD);

    vga_cell_fifo #(.DEPTH(FIFO_DEP)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (line_req),
        .push  (fifo_push),
        .wdata (push_cell),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Fetch sequencing; line_req restarts the line from any state.
    always_comb begin
        state_nx = state;
        col_nx   = col;
        if (line_req) begin
            state_nx = ST_TXT_REQ;
            col_nx   = '0;
        end else begin
            case (state)
                ST_IDLE:    state_nx = ST_IDLE;
                ST_TXT_REQ: if (txt_ack) state_nx = ST_ROM_RD;
                ST_ROM_RD:  state_nx = ST_ROM_DAT;
                ST_ROM_DAT: begin
                    col_nx = col + COL_W'(1);
                    if (col_nx == COL_W'(COLS)) state_nx = ST_IDLE;
                    else if (fill_after)        state_nx = ST_WAIT;
                    else                        state_nx = ST_TXT_REQ;
                end
                ST_WAIT:    if (!fifo_full) state_nx = ST_TXT_REQ;
                default:    state_nx = ST_IDLE;
            endcase
        end
    end

    // State plus registered text RAM and char ROM port outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            col       <= '0;
            base_q    <= '0;
            row_q     <= '0;
            attr_q    <= '0;
            txt_req   <= 1'b0;
            txt_addr  <= '0;
            rom_cs    <= 1'b0;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= '0;
            cpu_ack   <= 1'b0;
        end else begin
            state <= state_nx;
            col   <= col_nx;
            if (line_req) begin
                base_q <= line_base;
                row_q  <= line_row;
            end
            txt_req <= (state_nx == ST_TXT_REQ);
            if (state_nx == ST_TXT_REQ) begin
                txt_addr <= (line_req ? line_base : base_q) + ADDR_W'(col_nx);
            end
            if (state_nx == ST_ROM_RD) begin
                attr_q <= txt_data[15:8];
            end
            rom_cs  <= (state_nx == ST_ROM_RD) | cpu_go;
            rom_we  <= cpu_go;
            cpu_ack <= cpu_go;
            if (state_nx == ST_ROM_RD) begin
                rom_addr <= {txt_data[7:0], row_q};
            end else if (cpu_go) begin
                rom_addr  <= cpu_addr;
                rom_wdata <= cpu_wdata;
            end
        end
    end

    // Pixel serialiser: a cell is taken at bit 0 and shifted out MSB first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            cur_q     <= '0;
            pix_color <= '0;
            underrun  <= 1'b0;
        end else begin
            if (!de) begin
                bit_cnt   <= '0;
                pix_color <= '0;
            end else if (bit_cnt == 3'd0) begin
                cur_q     <= pop_cell;
                pix_color <= pix_colour(pop_cell.attr, pop_cell.font[7], blink);
                bit_cnt   <= 3'd1;
                if (fifo_empty) underrun <= 1'b1;
            end else begin
                pix_color <= pix_colour(cur_q.attr, cur_q.font[3'd7 - bit_cnt], blink);
                bit_cnt   <= bit_cnt + 3'd1;
            end
            if (line_req) underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_text_fetch.sv
// Directed-plus-random bench for vga_text_fetch with text RAM / char ROM models and a pixel reference.
module tb_vga_text_fetch;

    localparam int COLS   = 80;
    localparam int ADDR_W = 12;
    localparam int DEP    = 2;
    localparam int NPIX   = COLS * 8;

    logic              clk;
    logic              rst;
    logic              line_req;
    logic [ADDR_W-1:0] line_base;
    logic [3:0]        line_row;
    logic              de;
    logic              blink;
    logic              txt_req;
    logic [ADDR_W-1:0] txt_addr;
    logic              txt_ack;
    logic [15:0]       txt_data;
    logic              rom_cs;
    logic              rom_we;
    logic [11:0]       rom_addr;
    logic [7:0]        rom_wdata;
    logic [7:0]        rom_rdata;
    logic              cpu_we;
    logic [11:0]       cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [3:0]        pix_color;
    logic              underrun;

    vga_text_fetch #(.COLS(COLS), .ADDR_W(ADDR_W), .FIFO_DEP(DEP)) dut (
        .clk(clk), .rst(rst), .line_req(line_req), .line_base(line_base), .line_row(line_row),
        .de(de), .blink(blink), .txt_req(txt_req), .txt_addr(txt_addr), .txt_ack(txt_ack),
        .txt_data(txt_data), .rom_cs(rom_cs), .rom_we(rom_we), .rom_addr(rom_addr),
        .rom_wdata(rom_wdata), .rom_rdata(rom_rdata), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .pix_color(pix_color), .underrun(underrun)
    );

    logic [15:0] ram      [4096];
    logic [7:0]  font_ref [4096];
    logic [7:0]  rom_mem  [4096];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int wr_cnt = 0;
    int ack_cnt = 0;
    int ack_lat = 0;
    int ack_pct = 100;
    int stall_until = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && txt_req && txt_ack) hs_cnt++;
        if (rom_cs && rom_we) wr_cnt++;
        if (cpu_ack) ack_cnt++;
    end

    function automatic logic [7:0] font_init(input logic [11:0] a);
        if (a == 12'h415) return 8'hC6;
        if (a[11:4] == 8'hDB) return 8'hFF;
        return 8'(a * 12'd157) ^ 8'(a >> 4) ^ 8'h5A;
    endfunction

    // Char ROM: one-cycle synchronous read, write on cs&we.
    initial begin : rom_model
        for (int i = 0; i < 4096; i++) rom_mem[i] = font_init(12'(i));
        rom_rdata <= 8'h00;
        forever begin
            @(posedge clk);
            if (rom_cs && rom_we) rom_mem[rom_addr] = rom_wdata;
            else if (rom_cs)      rom_rdata <= rom_mem[rom_addr];
        end
    end

    // Text RAM: acks after ack_lat cycles of request, blocked until stall_until.
    initial begin : txt_responder
        int age;
        age = 0;
        txt_ack = 1'b0;
        txt_data = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            age = txt_req ? age + 1 : 0;
            if (rst && txt_req && age > ack_lat && cyc >= stall_until &&
                int'($urandom_range(99)) < ack_pct) begin
                txt_ack = 1'b1;
                txt_data = ram[txt_addr];
            end else begin
                txt_ack = 1'b0;
                txt_data = 16'($urandom);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pixel k of a line: cell k/8, glyph bit 7-(k%8), colour rule with blink.
    function automatic logic [3:0] exp_pix(input logic [11:0] base, input logic [3:0] row,
                                           input logic blk, input int k);
        logic [15:0] w;
        logic [7:0]  g;
        logic        b;
        logic        on;
        w  = ram[12'(base + 12'(k / 8))];
        g  = font_ref[{w[7:0], row}];
        b  = g[3'(7 - (k % 8))];
        on = b & ~(w[15] & blk);
        return on ? w[11:8] : {1'b0, w[14:12]};
    endfunction

    task automatic start_line(input logic [11:0] base, input logic [3:0] row);
        line_base = base;
        line_row  = row;
        line_req  = 1'b1;
        step();
        line_req  = 1'b0;
    endtask

    task automatic run_pixels(input string tag, input logic [11:0] base, input logic [3:0] row,
                              input logic blk, input int from, input int n);
        blink = blk;
        de = 1'b1;
        for (int k = from; k < from + n; k++) begin
            step();
            check(tag, 32'(pix_color), 32'(exp_pix(base, row, blk, k)));
        end
    endtask

    task automatic end_de();
        de = 1'b0;
        step();
        check("de_low_pix", 32'(pix_color), 32'h0);
    endtask

    initial begin : main
        logic [11:0] base;
        logic [11:0] base_b;
        logic [3:0]  row;
        logic        blk;
        logic        seen;
        logic [3:0]  t1_exp [8];
        int h0;
        int w0;
        int a0;

        rst = 1'b0; line_req = 1'b0; line_base = '0; line_row = '0; de = 1'b0; blink = 1'b0;
        cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        for (int i = 0; i < 4096; i++) begin
            ram[i]      = 16'($urandom);
            font_ref[i] = font_init(12'(i));
        end

        // Reset state
        repeat (3) step();
        check("rst_txt_req", 32'(txt_req), 0);
        check("rst_txt_addr", 32'(txt_addr), 0);
        check("rst_rom_cs", 32'(rom_cs), 0);
        check("rst_rom_we", 32'(rom_we), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_rom_wdata", 32'(rom_wdata), 0);
        check("rst_cpu_ack", 32'(cpu_ack), 0);
        check("rst_pix", 32'(pix_color), 0);
        check("rst_underrun", 32'(underrun), 0);
        rst = 1'b1;
        repeat (3) step();
        check("idle_no_req", 32'(txt_req), 0);

        // Directed first cell with late ack
        ram[12'h100] = 16'h1741;
        ack_lat = 1;
        start_line(12'h100, 4'd5);
        check("t1_txt_req", 32'(txt_req), 1);
        check("t1_txt_addr", 32'(txt_addr), 32'h100);
        for (int n = 0; n < 10 && !(rom_cs && !rom_we); n++) step();
        check("t1_rom_rd", 32'({rom_cs, rom_we}), 32'b10);
        check("t1_rom_addr", 32'(rom_addr), 32'h415);
        repeat (16) step();
        t1_exp = '{4'd7, 4'd7, 4'd1, 4'd1, 4'd1, 4'd7, 4'd7, 4'd1};
        blink = 1'b0;
        de = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("t1_pix", 32'(pix_color), 32'(t1_exp[k]));
        end
        run_pixels("t1_line", 12'h100, 4'd5, 1'b0, 8, NPIX - 8);
        end_de();
        check("t1_underrun", 32'(underrun), 0);

        // Full random lines, including an address wrap
        for (int l = 0; l < 3; l++) begin
            base = (l == 2) ? 12'hFE0 : 12'($urandom);
            row  = 4'($urandom);
            blk  = 1'($urandom);
            ack_lat = int'($urandom_range(2));
            h0 = hs_cnt;
            start_line(base, row);
            repeat (16) step();
            run_pixels("t2_pix", base, row, blk, 0, NPIX);
            end_de();
            repeat (4) step();
            check("t2_handshakes", 32'(hs_cnt - h0), 32'(COLS));
            check("t2_underrun", 32'(underrun), 0);
            check("t2_idle", 32'(txt_req), 0);
        end

        // Text RAM stall drains the FIFO
        ack_lat = 0;
        base = 12'($urandom);
        row  = 4'($urandom);
        start_line(base, row);
        repeat (16) step();
        run_pixels("t3_pre", base, row, 1'b0, 0, 100);
        check("t3_no_underrun", 32'(underrun), 0);
        stall_until = cyc + 40;
        for (int k = 100; k < 136; k++) step();
        for (int k = 136; k < 144; k++) begin
            step();
            check("t3_zero_pix", 32'(pix_color), 0);
        end
        check("t3_underrun", 32'(underrun), 1);
        for (int k = 144; k < NPIX; k++) step();
        end_de();
        check("t3_sticky", 32'(underrun), 1);
        base = 12'($urandom);
        h0 = hs_cnt;
        start_line(base, row);
        check("t3_cleared", 32'(underrun), 0);
        repeat (16) step();
        run_pixels("t3_next", base, row, 1'b0, 0, NPIX);
        end_de();
        check("t3_next_hs", 32'(hs_cnt - h0), 32'(COLS));
        check("t3_next_underrun", 32'(underrun), 0);

        // CPU font write during a fetch burst, then read back through the pixel path
        cpu_addr  = 12'($urandom);
        cpu_wdata = 8'($urandom);
        row  = cpu_addr[3:0] ^ 4'h8;
        base = 12'($urandom);
        w0 = wr_cnt;
        a0 = ack_cnt;
        start_line(base, row);
        repeat ($urandom_range(1, 4)) step();
        cpu_we = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            if (cpu_ack) begin
                seen = 1'b1;
                check("t4_we", 32'({rom_cs, rom_we}), 32'b11);
                check("t4_addr", 32'(rom_addr), 32'(cpu_addr));
                check("t4_wdata", 32'(rom_wdata), 32'(cpu_wdata));
                cpu_we = 1'b0;
            end
        end
        cpu_we = 1'b0;
        check("t4_acked", 32'(seen), 1);
        repeat (12) step();
        check("t4_writes", 32'(wr_cnt - w0), 1);
        check("t4_acks", 32'(ack_cnt - a0), 1);
        font_ref[cpu_addr] = cpu_wdata;
        run_pixels("t4_burst_line", base, row, 1'b0, 0, NPIX);
        end_de();
        base = 12'($urandom);
        for (int j = 0; j < 4; j++) ram[12'(base + 12'(j))] = {8'($urandom), cpu_addr[11:4]};
        start_line(base, cpu_addr[3:0]);
        repeat (16) step();
        run_pixels("t4_readback", base, cpu_addr[3:0], 1'b0, 0, NPIX);
        end_de();

        // Blinking glyph with attr 0x8F over a solid glyph
        base = 12'($urandom);
        row  = 4'($urandom);
        for (int j = 0; j < COLS; j++) ram[12'(base + 12'(j))] = 16'h8FDB;
        for (int b = 1; b >= 0; b--) begin
            start_line(base, row);
            repeat (16) step();
            blink = 1'(b);
            de = 1'b1;
            for (int k = 0; k < 64; k++) begin
                step();
                check(b ? "t5_blink_hidden" : "t5_blink_shown", 32'(pix_color), b ? 32'h0 : 32'hF);
            end
            end_de();
        end

        // Abort with one cell queued, then asynchronous reset mid-line
        ack_lat = 5;
        base = 12'($urandom);
        row  = 4'($urandom);
        start_line(base, row);
        repeat (10) step();
        check("t6_in_txt_req", 32'(txt_req), 1);
        ack_lat = 0;
        base_b = base + 12'h400;
        start_line(base_b, row);
        check("t6_new_addr", 32'(txt_addr), 32'(base_b));
        repeat (16) step();
        run_pixels("t6_flushed", base_b, row, 1'b0, 0, 50);
        rst = 1'b0;
        #1;
        check("t6_rst_txt_req", 32'(txt_req), 0);
        check("t6_rst_txt_addr", 32'(txt_addr), 0);
        check("t6_rst_rom_cs", 32'(rom_cs), 0);
        check("t6_rst_rom_addr", 32'(rom_addr), 0);
        check("t6_rst_cpu_ack", 32'(cpu_ack), 0);
        check("t6_rst_pix", 32'(pix_color), 0);
        check("t6_rst_underrun", 32'(underrun), 0);
        de = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        repeat (5) step();
        check("t6_idle_req", 32'(txt_req), 0);
        check("t6_idle_rom", 32'(rom_cs), 0);
        check("t6_idle_pix", 32'(pix_color), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
